// File: rtl/note_judge.sv
// Rhythm-game note judge: queues upcoming notes, grades the oldest one against
// song time and fret strobes, and keeps score, streak and multiplier.
module note_judge #(
  parameter int DEPTH         = 4,
  parameter int WINDOW        = 100,
  parameter int SCORE_PER_HIT = 50,
  parameter int MULT_STEP     = 10,
  parameter int MAX_MULT      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pause,
  input  logic [15:0]              song_time,
  input  logic                     note_valid,
  input  logic [15:0]              note_time,
  input  logic [4:0]               note_fret,
  output logic                     note_ready,
  input  logic                     fret_valid,
  input  logic [4:0]               fret,
  output logic                     hit,
  output logic                     miss,
  output logic [4:0]               judged_fret,
  output logic [23:0]              score,
  output logic [9:0]               streak,
  output logic [2:0]               multiplier,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(MULT_STEP + 1);
  localparam logic [15:0] WIN16 = 16'(WINDOW);
  localparam logic [16:0] WIN17 = 17'(WINDOW);
  localparam logic [23:0] SPH   = 24'(SCORE_PER_HIT);

  logic [15:0]   r_q_time [DEPTH];
  logic [4:0]    r_q_fret [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [PW-1:0] r_pending;
  logic          r_hit;
  logic          r_miss;
  logic [4:0]    r_judged_fret;
  logic [23:0]   r_score;
  logic [9:0]    r_streak;
  logic [2:0]    r_mult;
  logic [SW-1:0] r_step;

  logic          w_push;
  logic          w_pop;
  logic          w_judge;
  logic          w_hit;
  logic          w_miss;
  logic [15:0]   w_head_time;
  logic [4:0]    w_head_fret;
  logic [15:0]   w_early;
  logic [16:0]   w_late17;
  logic [15:0]   w_late;
  logic [23:0]   w_add;
  logic [24:0]   w_sum;
  logic [23:0]   w_score_nxt;
  logic [SW-1:0] w_step_inc;

  // Full blocks a push even when a pop lands in the same cycle.
  assign note_ready = reset_n & (r_pending < PW'(DEPTH));
  assign w_push     = note_valid & note_ready;

  assign w_head_time = r_q_time[r_rd_ptr];
  assign w_head_fret = r_q_fret[r_rd_ptr];

  assign w_early  = (w_head_time < WIN16) ? 16'd0 : (w_head_time - WIN16);
  assign w_late17 = {1'b0, w_head_time} + WIN17;
  assign w_late   = w_late17[16] ? 16'hFFFF : w_late17[15:0];

  assign w_judge = !pause && (r_pending != '0);
  assign w_hit   = w_judge && fret_valid && (fret == w_head_fret) &&
                   (song_time >= w_early) && (song_time <= w_late);
  assign w_miss  = w_judge && (song_time > w_late);
  assign w_pop   = w_hit | w_miss;

  // Points use the multiplier in force before this hit is counted.
  assign w_add       = SPH * {21'd0, r_mult};
  assign w_sum       = {1'b0, r_score} + {1'b0, w_add};
  assign w_score_nxt = w_sum[24] ? 24'hFFFFFF : w_sum[23:0];
  assign w_step_inc  = r_step + SW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_time[r_wr_ptr] <= note_time;
      r_q_fret[r_wr_ptr] <= note_fret;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pending     <= '0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_judged_fret <= '0;
      r_score       <= '0;
      r_streak      <= '0;
      r_mult        <= 3'd1;
      r_step        <= '0;
    end else begin
      r_hit  <= w_hit;
      r_miss <= w_miss;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_pending <= r_pending + PW'(1);
        2'b01:   r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
      if (w_hit) begin
        r_judged_fret <= w_head_fret;
        r_score       <= w_score_nxt;
        if (r_streak != 10'd1023) r_streak <= r_streak + 10'd1;
        if (w_step_inc == SW'(MULT_STEP)) begin
          r_step <= '0;
          if (r_mult < 3'(MAX_MULT)) r_mult <= r_mult + 3'd1;
        end else begin
          r_step <= w_step_inc;
        end
      end else if (w_miss) begin
        r_judged_fret <= w_head_fret;
        r_streak      <= '0;
        r_step        <= '0;
        r_mult        <= 3'd1;
      end
    end
  end

  assign hit         = r_hit;
  assign miss        = r_miss;
  assign judged_fret = r_judged_fret;
  assign score       = r_score;
  assign streak      = r_streak;
  assign multiplier  = r_mult;
  assign pending     = r_pending;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: expected judgements are queued as stimulus is
// driven and compared against each hit/miss pulse as it appears.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] song_time = '0;
  logic        note_valid = 1'b0;
  logic [15:0] note_time = '0;
  logic [4:0]  note_fret = '0;
  logic        fret_valid = 1'b0;
  logic [4:0]  fret = '0;
  logic        note_ready;
  logic        hit;
  logic        miss;
  logic [4:0]  judged_fret;
  logic [23:0] score;
  logic [9:0]  streak;
  logic [2:0]  multiplier;
  logic [2:0]  pending;

  note_judge dut (
    .clk(clk), .reset_n(reset_n), .pause(pause), .song_time(song_time),
    .note_valid(note_valid), .note_time(note_time), .note_fret(note_fret),
    .note_ready(note_ready), .fret_valid(fret_valid), .fret(fret),
    .hit(hit), .miss(miss), .judged_fret(judged_fret), .score(score),
    .streak(streak), .multiplier(multiplier), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_hit;
    logic [4:0]  jf;
    logic [23:0] sc;
    logic [9:0]  st;
    logic [2:0]  mu;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int m_score, m_streak, m_mult, m_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_judge(input logic is_hit, input logic [4:0] f);
    exp_t e;
    if (is_hit) begin
      m_score = m_score + 50 * m_mult;
      if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
      if (m_streak < 1023) m_streak++;
      m_step++;
      if (m_step == 10) begin
        m_step = 0;
        if (m_mult < 4) m_mult++;
      end
    end else begin
      m_streak = 0;
      m_step = 0;
      m_mult = 1;
    end
    e.is_hit = is_hit;
    e.jf = f;
    e.sc = 24'(m_score);
    e.st = 10'(m_streak);
    e.mu = 3'(m_mult);
    sb.push_back(e);
  endtask

  task automatic wait_out(input string tag, input int budget);
    int waited = 0;
    exp_t e;
    while (!(hit | miss) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    assert ((hit | miss) === 1'b1 && sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s: no judgement (hit=%b miss=%b queued=%0d) after %0d cycles, expected one",
             tag, hit, miss, sb.size(), waited);
    end
    if ((hit | miss) && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " hit"}, 32'(hit), 32'(e.is_hit));
      chk({tag, " miss"}, 32'(miss), 32'(!e.is_hit));
      chk({tag, " judged_fret"}, 32'(judged_fret), 32'(e.jf));
      chk({tag, " score"}, 32'(score), 32'(e.sc));
      chk({tag, " streak"}, 32'(streak), 32'(e.st));
      chk({tag, " multiplier"}, 32'(multiplier), 32'(e.mu));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    note_valid = 1'b0;
    fret_valid = 1'b0;
    #1 chk("rst note_ready low", 32'(note_ready), 0);
    @(negedge clk);
    chk("rst pending", 32'(pending), 0);
    chk("rst score", 32'(score), 0);
    chk("rst streak", 32'(streak), 0);
    chk("rst multiplier", 32'(multiplier), 1);
    chk("rst hit", 32'(hit), 0);
    chk("rst miss", 32'(miss), 0);
    chk("rst judged_fret", 32'(judged_fret), 0);
    @(negedge clk);
    chk("rst note_ready held low", 32'(note_ready), 0);
    reset_n = 1'b1;
    #1 chk("rst release note_ready", 32'(note_ready), 1);
    m_score = 0; m_streak = 0; m_mult = 1; m_step = 0;
    sb.delete();
  endtask

  task automatic push_note(input logic [15:0] t, input logic [4:0] f);
    note_valid = 1'b1;
    note_time = t;
    note_fret = f;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic strike(input logic [4:0] f);
    fret_valid = 1'b1;
    fret = f;
    @(negedge clk);
    fret_valid = 1'b0;
  endtask

  task automatic strike_hit(input string tag, input logic [4:0] f);
    expect_judge(1'b1, f);
    strike(f);
    wait_out(tag, 0);
  endtask

  initial begin
    int saved_score;
    @(negedge clk);
    do_reset();

    // basic hit
    song_time = 16'd950;
    push_note(16'd1000, 5'b00100);
    chk("t1 pending after push", 32'(pending), 1);
    strike_hit("t1 hit", 5'b00100);
    chk("t1 pending after hit", 32'(pending), 0);
    @(negedge clk);
    chk("t1 hit single pulse", 32'(hit), 0);

    // early strobe ignored, then miss exactly at late+1
    song_time = 16'd899;
    push_note(16'd1000, 5'b00100);
    strike(5'b00100);
    chk("t2 early strobe no hit", 32'(hit), 0);
    chk("t2 early strobe pending", 32'(pending), 1);
    for (int t = 1095; t <= 1101; t++) begin
      song_time = 16'(t);
      if (t == 1101) begin
        expect_judge(1'b0, 5'b00100);
        @(negedge clk);
        wait_out("t2 miss", 0);
      end else begin
        @(negedge clk);
        chk($sformatf("t2 no miss at %0d", t), 32'(miss), 0);
      end
    end
    chk("t2 pending after miss", 32'(pending), 0);

    // multiplier step after 10 hits
    do_reset();
    song_time = 16'd2000;
    for (int k = 1; k <= 11; k++) begin
      push_note(16'd2000, 5'b00010);
      strike_hit($sformatf("t3 hit%0d", k), 5'b00010);
      if (k == 10) begin
        chk("t3 mult after 10", 32'(multiplier), 2);
        chk("t3 score after 10", 32'(score), 500);
      end
      if (k == 11) begin
        chk("t3 score after 11", 32'(score), 600);
        chk("t3 streak after 11", 32'(streak), 11);
      end
    end

    // full queue, hit while upstream holds valid
    song_time = 16'd3000;
    note_valid = 1'b1;
    note_time = 16'd3000;
    note_fret = 5'b00001;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("t4 pending full", 32'(pending), 4);
    chk("t4 ready low full", 32'(note_ready), 0);
    @(negedge clk);
    chk("t4 fifth rejected", 32'(pending), 4);
    expect_judge(1'b1, 5'b00001);
    strike(5'b00001);
    wait_out("t4 hit while full", 0);
    chk("t4 pending after pop", 32'(pending), 3);
    chk("t4 ready reasserts", 32'(note_ready), 1);
    @(negedge clk);
    chk("t4 fifth accepted", 32'(pending), 4);
    note_valid = 1'b0;
    for (int i = 0; i < 4; i++) strike_hit($sformatf("t4 drain%0d", i), 5'b00001);
    chk("t4 drained", 32'(pending), 0);

    // pause freezes judging, pushes still accepted
    song_time = 16'd4000;
    push_note(16'd4000, 5'b01000);
    pause = 1'b1;
    saved_score = int'(score);
    strike(5'b01000);
    chk("t5 paused no hit", 32'(hit), 0);
    song_time = 16'd4200;
    push_note(16'd4500, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5 paused no miss %0d", i), 32'(miss), 0);
    end
    chk("t5 paused pending", 32'(pending), 2);
    chk("t5 paused score", 32'(score), 32'(saved_score));
    chk("t5 paused streak", 32'(streak), 32'(m_streak));
    pause = 1'b0;
    expect_judge(1'b0, 5'b01000);
    @(negedge clk);
    wait_out("t5 miss after unpause", 0);
    chk("t5 pending after miss", 32'(pending), 1);
    song_time = 16'd4600;
    strike_hit("t5 hit at late edge", 5'b01000);
    song_time = 16'd0;
    push_note(16'd50, 5'b10000);
    strike_hit("t5 hit early sat", 5'b10000);
    song_time = 16'd5900;
    push_note(16'd6000, 5'b00011);
    strike_hit("t5 hit at early edge", 5'b00011);
    song_time = 16'd7000;
    push_note(16'd7000, 5'b00011);
    strike(5'b00001);
    chk("t5 wrong fret ignored", 32'(hit), 0);
    strike_hit("t5 hit after wrong fret", 5'b00011);
    strike(5'b00011);
    chk("t5 empty queue strobe", 32'(hit), 0);

    // reset mid-operation discards queue
    song_time = 16'd9000;
    note_valid = 1'b1;
    note_time = 16'd9000;
    note_fret = 5'b00001;
    for (int i = 0; i < 3; i++) @(negedge clk);
    note_valid = 1'b0;
    chk("t6 pending before reset", 32'(pending), 3);
    do_reset();
    push_note(16'd9000, 5'b00100);
    chk("t6 pending after reset push", 32'(pending), 1);
    strike_hit("t6 fresh head", 5'b00100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
